serial_adder: RTL and testbench

- Bit-serial adder built around the existing one-bit `fulladder` cell (ports a, b, cin, sum, cout).
- The block is the sequential stage that feeds that cell one operand bit pair per clock, LSB first, and consumes its carry-out through a carry flip-flop.
- It assembles a WIDTH-bit sum over WIDTH cycles.
- It targets area-constrained datapaths where a WIDTH-bit ripple adder is not wanted.

---
 rtl/serial_adder.sv | 103 ++++++++++
 tb/tb_serial_adder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder that feeds a one-bit fulladder one operand bit pair per clock, LSB first
//   Parameter WIDTH (2..32): operand/sum width.
//   Ports: clk, rst_n (sync active-low), start, a, b, cin -> busy, done, sum, cout
//   Optional SERIAL_ADDER_OVF_EN: adds ovf (two's-complement overflow, valid with done).
//   fulladder: combinational one-bit full adder cell (a, b, cin -> sum, cout).
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry, r_cout;
    logic             w_fa_sum, w_fa_cout, w_last;
    fulladder u_fa (
        .a(r_a[0]),
        .b(r_b[0]),
        .cin(r_carry),
        .sum(w_fa_sum),
        .cout(w_fa_cout)
    );
    // last RUN edge: the MSB pair is in the cell right now
    assign w_last = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        busy = r_state != IDLE;
        done = r_state == DONE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= cin;
            r_cout  <= 1'b0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            // sum bits enter at the MSB and reach bit 0 after WIDTH shifts
            r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
            r_cnt   <= r_cnt + CW'(1);
            r_carry <= w_fa_cout;
            if (w_last) r_cout <= w_fa_cout;
        end
    end
    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;
    // overflow = carry into MSB xor carry out of MSB
    always_ff @(posedge clk) begin
        if (!rst_n)                        r_ovf <= 1'b0;
        else if (r_state == IDLE && start) r_ovf <= 1'b0;
        else if (w_last)                   r_ovf <= r_carry ^ w_fa_cout;
    end
    assign ovf = r_ovf;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized self-checking bench for serial_adder against an arithmetic reference model
module tb_serial_adder;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int           m_left = 0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a(a),
        .b(b),
        .cin(cin),
        .busy(busy),
        .done(done),
        .sum(sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf),
`endif
        .cout(cout)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int sval(logic [W-1:0] v);
        return v[W-1] ? int'(v) - (1 << W) : int'(v);
    endfunction

    // Reference: m_left counts remaining busy cycles; an accepted start yields W+1 busy cycles, the last being done.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                int s;
                m_left = W + 1;
                {m_cout, m_sum} = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
                s = sval(a) + sval(b) + int'(cin);
                m_ovf = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
            end
        end else begin
            m_left--;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_left > 0);
            chk("done", done, m_left == 1);
            if (m_left <= 1) begin
                chk("sum", sum, m_sum);
                chk("cout", cout, m_cout);
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", ovf, m_ovf);
`endif
            end
        end
    end

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic [W-1:0] es, input logic ec, input logic eo);
        int n = 0;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; cin = tc;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(negedge clk);
            n++;
        end
        chk("latency", n, W + 1);
        chk("lit_sum", sum, es);
        chk("lit_cout", cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
        chk("lit_ovf", ovf, eo);
`else
        if (eo) begin end
`endif
    endtask

    initial begin
        int n, dones;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk_en = 1'b1;
        op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0);
        op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);
        // start pulses during RUN and DONE must be ignored
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        dones = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = (i == 3) || (done && dones == 0);
            a = 8'hFF; b = 8'hFF;
            if (done) begin
                dones++;
                chk("coll_sum", sum, 8'h30);
                chk("coll_cout", cout, 0);
            end
        end
        start = 1'b0;
        chk("coll_dones", dones, 1);
        // reset in RUN aborts without a done pulse
        @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_dones", dones, 0);
        // fully random inputs, including mid-flight starts and occasional resets
        n = 0;
        repeat (1500) begin
            @(negedge clk);
            start = 1'($urandom);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            rst_n = $urandom_range(0, 199) != 0;
            if (done) n++;
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (W + 3) @(negedge clk);
        if (n < 20) chk("random_ops", n, 20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
